// File: rtl/wir_ctrl.sv
// IEEE 1500 wrapper instruction register and WSP sequencer for one wrapped core.
// Optional feature: define WIR_PARITY_EN to add an even-parity bit to the WIR shift path.
module wir_ctrl #(
    parameter int WIR_WIDTH = 3
) (
    input  logic                 wrck,
    input  logic                 wrstn,
    input  logic                 selectwir,
    input  logic                 capturewr,
    input  logic                 shiftwr,
    input  logic                 updatewr,
    input  logic                 wsi,
    input  logic                 wby_wso,
    input  logic                 wbr_wso,
    output logic                 wso,
    output logic                 shiftwby,
    output logic                 capturewbr,
    output logic                 shiftwbr,
    output logic                 updatewbr,
    output logic [WIR_WIDTH-1:0] wir_inst,
    output logic [1:0]           wrap_mode,
    output logic                 proto_err
);

`ifdef WIR_PARITY_EN
    localparam int SR_W = WIR_WIDTH + 1;
    localparam logic [SR_W-1:0] CAP_VAL = {1'b1, WIR_WIDTH'(2'b01)};
`else
    localparam int SR_W = WIR_WIDTH;
    localparam logic [SR_W-1:0] CAP_VAL = SR_W'(2'b01);
`endif

    localparam logic [WIR_WIDTH-1:0] WS_EXTEST  = WIR_WIDTH'(1);
    localparam logic [WIR_WIDTH-1:0] WS_INTEST  = WIR_WIDTH'(2);
    localparam logic [WIR_WIDTH-1:0] WS_SAFE    = WIR_WIDTH'(3);
    localparam logic [WIR_WIDTH-1:0] WS_PRELOAD = WIR_WIDTH'(4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_UPDATE
    } state_t;

    state_t                r_state;
    logic [SR_W-1:0]       r_sr;
    logic [WIR_WIDTH-1:0]  r_wir_inst;
    logic                  r_wso;
    logic                  r_err_pos;
    logic                  r_err_neg;
    logic                  r_err_cycle;

    logic                  w_multi;
    logic                  w_byp;
    logic                  w_ops_en;
    logic [1:0]            w_mode;

    assign w_multi = (capturewr & shiftwr) | (capturewr & updatewr) | (shiftwr & updatewr);

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        w_byp  = 1'b1;
        w_mode = 2'b00;
        case (r_wir_inst)
            WS_EXTEST:  begin w_byp = 1'b0; w_mode = 2'b01; end
            WS_INTEST:  begin w_byp = 1'b0; w_mode = 2'b10; end
            WS_SAFE:    begin w_byp = 1'b0; w_mode = 2'b11; end
            WS_PRELOAD: begin w_byp = 1'b0; w_mode = 2'b00; end
            default:    begin w_byp = 1'b1; w_mode = 2'b00; end
        endcase
    end

    // Data-register enables are forced low in reset and on a conflicting-op cycle.
    assign w_ops_en   = wrstn & ~selectwir & ~w_multi;
    assign shiftwby   = w_ops_en & shiftwr   &  w_byp;
    assign capturewbr = w_ops_en & capturewr & ~w_byp;
    assign shiftwbr   = w_ops_en & shiftwr   & ~w_byp;
    assign updatewbr  = w_ops_en & updatewr  & ~w_byp;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wrck or negedge wrstn) begin
        if (!wrstn) begin
            r_state     <= ST_IDLE;
            r_sr        <= '0;
            r_err_pos   <= 1'b0;
            r_err_cycle <= 1'b0;
        end else begin
            r_err_cycle <= w_multi;
            if (w_multi) begin
                r_err_pos <= 1'b1;
                r_state   <= ST_IDLE;
            end else begin
                if (selectwir && capturewr) begin
                    r_sr <= CAP_VAL;
                end else if (selectwir && shiftwr) begin
                    r_sr <= {wsi, r_sr[SR_W-1:1]};
                end
                case (r_state)
                    ST_IDLE: begin
                        if (capturewr) r_state <= ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        if (shiftwr)       r_state <= ST_SHIFT;
                        else if (updatewr) r_state <= ST_UPDATE;
                    end
                    ST_SHIFT: begin
                        if (updatewr)       r_state <= ST_UPDATE;
                        else if (capturewr) r_state <= ST_CAPTURE;
                    end
                    ST_UPDATE: begin
                        if (capturewr)     r_state <= ST_CAPTURE;
                        else if (!shiftwr) r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Update and WSO retiming happen on the falling edge, half a cycle after capture/shift.
    always_ff @(negedge wrck or negedge wrstn) begin
        if (!wrstn) begin
            r_wir_inst <= '0;
            r_wso      <= 1'b0;
            r_err_neg  <= 1'b0;
        end else begin
            r_wso <= selectwir ? r_sr[0] : (w_byp ? wby_wso : wbr_wso);
            if (selectwir && updatewr && !r_err_cycle) begin
`ifdef WIR_PARITY_EN
                if (^r_sr) r_err_neg  <= 1'b1;
                else       r_wir_inst <= r_sr[WIR_WIDTH-1:0];
`else
                r_wir_inst <= r_sr;
`endif
            end
        end
    end

    assign wso       = r_wso;
    assign wir_inst  = r_wir_inst;
    assign wrap_mode = w_mode;
    assign proto_err = r_err_pos | r_err_neg;

endmodule

// File: tb/tb_wir_ctrl.sv
// Directed bench for wir_ctrl: vector table for the main WSP sequences plus hand-written
// sequences for async reset, the 8-cycle bypass shift and (with WIR_PARITY_EN) parity checking.
module tb_wir_ctrl;

    logic       wrck, wrstn, selectwir, capturewr, shiftwr, updatewr, wsi, wby_wso, wbr_wso;
    logic       wso, shiftwby, capturewbr, shiftwbr, updatewbr, proto_err;
    logic [2:0] wir_inst;
    logic [1:0] wrap_mode;

    int checks   = 0;
    int failures = 0;

    wir_ctrl #(.WIR_WIDTH(3)) dut (
        .wrck       (wrck),
        .wrstn      (wrstn),
        .selectwir  (selectwir),
        .capturewr  (capturewr),
        .shiftwr    (shiftwr),
        .updatewr   (updatewr),
        .wsi        (wsi),
        .wby_wso    (wby_wso),
        .wbr_wso    (wbr_wso),
        .wso        (wso),
        .shiftwby   (shiftwby),
        .capturewbr (capturewbr),
        .shiftwbr   (shiftwbr),
        .updatewbr  (updatewbr),
        .wir_inst   (wir_inst),
        .wrap_mode  (wrap_mode),
        .proto_err  (proto_err)
    );

    initial wrck = 1'b0;
    always #5 wrck = ~wrck;

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish (checks=%0d)", checks);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       sel, cap, sh, upd, wsi, wby, wbr;
        logic       e_shwby, e_capwbr, e_shwbr, e_updwbr;
        logic [2:0] e_wir;
        logic       e_wso;
        logic [1:0] e_mode;
        logic       e_perr;
    } vec_t;

    vec_t vecs[41];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic sel, cap, sh, upd, di, wby, wbr);
        selectwir = sel; capturewr = cap; shiftwr = sh; updatewr = upd;
        wsi = di; wby_wso = wby; wbr_wso = wbr;
    endtask

    // Drive one WSP cycle (starting just after a negedge) and advance to just after the next negedge.
    task automatic step(input logic sel, cap, sh, upd, di);
        drive(sel, cap, sh, upd, di, 1'b0, 1'b0);
        @(negedge wrck); #1;
    endtask

    task automatic check_enables(input string tag, input logic wby, cwbr, swbr, uwbr);
        check({tag, " shiftwby"},   int'(shiftwby),   int'(wby));
        check({tag, " capturewbr"}, int'(capturewbr), int'(cwbr));
        check({tag, " shiftwbr"},   int'(shiftwbr),   int'(swbr));
        check({tag, " updatewbr"},  int'(updatewbr),  int'(uwbr));
    endtask

    initial begin
        //          sel cap sh upd wsi wby wbr  shwby cwbr swbr uwbr  wir   wso mode  perr
        vecs[0]  = '{1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  3'd0, 1, 2'd0, 0};
        vecs[1]  = '{1, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0,  3'd0, 0, 2'd0, 0};
        vecs[2]  = '{1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  3'd0, 0, 2'd0, 0};
        vecs[3]  = '{1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  3'd0, 1, 2'd0, 0};
        vecs[4]  = '{1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0,  3'd1, 1, 2'd1, 0};
        vecs[5]  = '{0, 0, 1, 0, 0, 0, 1,  0, 0, 1, 0,  3'd1, 1, 2'd1, 0};
        vecs[6]  = '{0, 1, 0, 0, 0, 1, 0,  0, 1, 0, 0,  3'd1, 0, 2'd1, 0};
        vecs[7]  = '{0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 1,  3'd1, 1, 2'd1, 0};
        vecs[8]  = '{1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  3'd1, 1, 2'd1, 0};
        vecs[9]  = '{1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  3'd1, 0, 2'd1, 0};
        vecs[10] = '{1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  3'd1, 0, 2'd1, 0};
        vecs[11] = '{1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  3'd1, 0, 2'd1, 0};
        vecs[12] = '{1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0,  3'd0, 0, 2'd0, 0};
        vecs[13] = '{0, 0, 1, 0, 0, 1, 0,  1, 0, 0, 0,  3'd0, 1, 2'd0, 0};
        vecs[14] = '{0, 0, 1, 0, 0, 0, 1,  1, 0, 0, 0,  3'd0, 0, 2'd0, 0};
        vecs[15] = '{0, 1, 0, 0, 0, 1, 1,  0, 0, 0, 0,  3'd0, 1, 2'd0, 0};
        vecs[16] = '{0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 0,  3'd0, 0, 2'd0, 0};
        vecs[17] = '{1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  3'd0, 1, 2'd0, 0};
        vecs[18] = '{1, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0,  3'd0, 0, 2'd0, 0};
        vecs[19] = '{1, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0,  3'd0, 0, 2'd0, 0};
        vecs[20] = '{1, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0,  3'd0, 1, 2'd0, 0};
        vecs[21] = '{1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0,  3'd7, 1, 2'd0, 0};
        vecs[22] = '{0, 0, 1, 0, 0, 1, 0,  1, 0, 0, 0,  3'd7, 1, 2'd0, 0};
        vecs[23] = '{1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0,  3'd7, 1, 2'd0, 1};
        vecs[24] = '{1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0,  3'd7, 1, 2'd0, 1};
        vecs[25] = '{1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  3'd7, 1, 2'd0, 1};
        vecs[26] = '{1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0,  3'd7, 1, 2'd0, 1};
        vecs[27] = '{1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0,  3'd1, 1, 2'd1, 1};
        vecs[28] = '{1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  3'd1, 1, 2'd1, 1};
        vecs[29] = '{1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  3'd1, 0, 2'd1, 1};
        vecs[30] = '{0, 0, 1, 0, 1, 0, 1,  0, 0, 1, 0,  3'd1, 1, 2'd1, 1};
        vecs[31] = '{1, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0,  3'd1, 0, 2'd1, 1};
        vecs[32] = '{1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  3'd1, 0, 2'd1, 1};
        vecs[33] = '{1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0,  3'd2, 0, 2'd2, 1};
        vecs[34] = '{1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  3'd2, 1, 2'd2, 1};
        vecs[35] = '{1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  3'd2, 0, 2'd2, 1};
        vecs[36] = '{1, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  3'd2, 0, 2'd2, 1};
        vecs[37] = '{1, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0,  3'd2, 0, 2'd2, 1};
        vecs[38] = '{1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0,  3'd4, 0, 2'd0, 1};
        vecs[39] = '{0, 0, 1, 0, 0, 0, 1,  0, 0, 1, 0,  3'd4, 1, 2'd0, 1};
        vecs[40] = '{0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 1,  3'd4, 0, 2'd0, 1};

        wrstn = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        check("reset wir_inst",  int'(wir_inst),  0);
        check("reset wso",       int'(wso),       0);
        check("reset proto_err", int'(proto_err), 0);
        check("reset wrap_mode", int'(wrap_mode), 0);
        check_enables("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #10 wrstn = 1'b1;
        @(negedge wrck); #1;

`ifndef WIR_PARITY_EN
        for (int i = 0; i < 41; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].sel, vecs[i].cap, vecs[i].sh, vecs[i].upd,
                  vecs[i].wsi, vecs[i].wby, vecs[i].wbr);
            #1;
            check_enables(tag, vecs[i].e_shwby, vecs[i].e_capwbr, vecs[i].e_shwbr, vecs[i].e_updwbr);
            @(negedge wrck); #1;
            check({tag, " wir_inst"},  int'(wir_inst),  int'(vecs[i].e_wir));
            check({tag, " wso"},       int'(wso),       int'(vecs[i].e_wso));
            check({tag, " wrap_mode"}, int'(wrap_mode), int'(vecs[i].e_mode));
            check({tag, " proto_err"}, int'(proto_err), int'(vecs[i].e_perr));
        end
`else
        // Code 010 with parity bit 0 (odd total) must be rejected.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("parity before update proto_err", int'(proto_err), 0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("bad parity wir_inst",  int'(wir_inst),  0);
        check("bad parity proto_err", int'(proto_err), 1);
        // Same code with parity bit 1 is accepted.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("good parity wir_inst",  int'(wir_inst),  2);
        check("good parity wrap_mode", int'(wrap_mode), 2);
        check("good parity proto_err", int'(proto_err), 1);
        // Capture followed directly by update reloads 01 with parity 1.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("capture-update wir_inst", int'(wir_inst), 1);
        // Three shifts then a fourth: shift a non-bypass code back so the reset test sees a WBR route.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("reload INTEST wir_inst", int'(wir_inst), 2);
`endif

        // Async reset in the middle of a WBR shift cycle.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("pre-reset shiftwbr", int'(shiftwbr), 1);
        @(negedge wrck); #1;
        check("pre-reset wso", int'(wso), 1);
        check("pre-reset proto_err", int'(proto_err), 1);
        @(posedge wrck); #2;
        wrstn = 1'b0;
        #1;
        check("midreset wir_inst",  int'(wir_inst),  0);
        check("midreset wso",       int'(wso),       0);
        check("midreset proto_err", int'(proto_err), 0);
        check_enables("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
        #3 wrstn = 1'b1;
        @(negedge wrck); #1;

        // Bypass active after reset: 8 shift cycles go to WBY, WSO follows wby_wso.
        for (int i = 0; i < 8; i++) begin
            logic b;
            b = (i % 3) == 1;
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b, ~b);
            #1;
            check($sformatf("byp%0d shiftwby", i), int'(shiftwby), 1);
            check($sformatf("byp%0d shiftwbr", i), int'(shiftwbr), 0);
            @(negedge wrck); #1;
            check($sformatf("byp%0d wso", i), int'(wso), int'(b));
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_enables("byp capture", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge wrck); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check_enables("byp update", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge wrck); #1;
        check("byp wir_inst", int'(wir_inst), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
